// File: rtl/rgb2gray_pipe.sv
// Three-stage valid/ready RGB-to-gray converter (avg, BT.601, max, green).
// Define RGB2GRAY_THRESH_EN to add the iTHRESH/oBIN dark-pupil mask output.
module rgb2gray_pipe #(
  parameter int unsigned DW       = 10,
  parameter int unsigned MODE_DEF = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iDVAL,
  output logic          oREADY,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic          iSOF,
  input  logic          iMODE_OVR,
  input  logic [1:0]    iMODE,
  output logic          oDVAL,
  input  logic          iREADY,
  output logic [DW-1:0] oDATA,
  output logic          oSOF
`ifdef RGB2GRAY_THRESH_EN
  ,
  input  logic [DW-1:0] iTHRESH,
  output logic          oBIN
`endif
);

  typedef enum logic [1:0] {MODE_AVG, MODE_601, MODE_MAX, MODE_GRN} mode_e;

  // floor(x/3) == (x*M)>>K exactly for every x < 2^(DW+2), since x*(3M-2^K) < 2^K
  localparam int unsigned DIV3_K = DW + 4;
  localparam int unsigned DIV3_M = ((1 << DIV3_K) + 2) / 3;
  localparam int unsigned PW     = 2 * DW + 6;

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DW-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic          sof1_q, sof1_d, sof2_q, sof2_d, sof3_q, sof3_d;
  mode_e         mode1_q, mode1_d, mode2_q, mode2_d;
  logic [DW+7:0] acc2_q, acc2_d;
  logic [DW-1:0] b2_q, b2_d, data3_q, data3_d;
  logic [DW-1:0] gray;
  logic          adv1, adv2, adv3, load1, load2, load3, in_xfer;
`ifdef RGB2GRAY_THRESH_EN
  logic [DW-1:0] thr1_q, thr1_d, thr2_q, thr2_d;
  logic          bin3_q, bin3_d;
`endif

  always_comb begin
    // a stage may load when empty or when its successor drains this cycle
    adv3    = v3_q & iREADY;
    load3   = !v3_q | adv3;
    adv2    = v2_q & load3;
    load2   = !v2_q | adv2;
    adv1    = v1_q & load2;
    load1   = !v1_q | adv1;
    oREADY  = load1;
    in_xfer = iDVAL & load1;

    v1_d    = in_xfer | (v1_q & !adv1);
    v2_d    = adv1 | (v2_q & !adv2);
    v3_d    = adv2 | (v3_q & !adv3);

    r1_d    = in_xfer ? iRed   : r1_q;
    g1_d    = in_xfer ? iGreen : g1_q;
    b1_d    = in_xfer ? iBlue  : b1_q;
    sof1_d  = in_xfer ? iSOF   : sof1_q;
    mode1_d = mode1_q;
    if (in_xfer) mode1_d = iMODE_OVR ? mode_e'(iMODE) : mode_e'(MODE_DEF[1:0]);

    acc2_d  = acc2_q;
    b2_d    = adv1 ? b1_q    : b2_q;
    sof2_d  = adv1 ? sof1_q  : sof2_q;
    mode2_d = adv1 ? mode1_q : mode2_q;
    if (adv1) begin
      unique case (mode1_q)
        MODE_AVG: acc2_d = (DW+8)'({2'b00, r1_q} + {2'b00, g1_q} + {2'b00, b1_q});
        MODE_601: acc2_d = (DW+8)'(r1_q) * (DW+8)'(77) + (DW+8)'(g1_q) * (DW+8)'(150)
                         + (DW+8)'(b1_q) * (DW+8)'(29) + (DW+8)'(128);
        MODE_MAX: acc2_d = (DW+8)'((r1_q > g1_q) ? r1_q : g1_q);
        MODE_GRN: acc2_d = (DW+8)'(g1_q);
        default:  acc2_d = '0;
      endcase
    end

    unique case (mode2_q)
      MODE_AVG: gray = DW'((PW'(acc2_q[DW+1:0]) * PW'(DIV3_M)) >> DIV3_K);
      MODE_601: gray = DW'(acc2_q >> 8);
      MODE_MAX: gray = (acc2_q[DW-1:0] > b2_q) ? acc2_q[DW-1:0] : b2_q;
      MODE_GRN: gray = acc2_q[DW-1:0];
      default:  gray = '0;
    endcase

    data3_d = adv2 ? gray   : data3_q;
    sof3_d  = adv2 ? sof2_q : sof3_q;
`ifdef RGB2GRAY_THRESH_EN
    thr1_d  = in_xfer ? iTHRESH : thr1_q;
    thr2_d  = adv1 ? thr1_q : thr2_q;
    bin3_d  = adv2 ? (gray < thr2_q) : bin3_q;
`endif
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      sof1_q  <= 1'b0;
      sof2_q  <= 1'b0;
      sof3_q  <= 1'b0;
      mode1_q <= MODE_AVG;
      mode2_q <= MODE_AVG;
      acc2_q  <= '0;
      b2_q    <= '0;
      data3_q <= '0;
`ifdef RGB2GRAY_THRESH_EN
      thr1_q  <= '0;
      thr2_q  <= '0;
      bin3_q  <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      r1_q    <= r1_d;
      g1_q    <= g1_d;
      b1_q    <= b1_d;
      sof1_q  <= sof1_d;
      sof2_q  <= sof2_d;
      sof3_q  <= sof3_d;
      mode1_q <= mode1_d;
      mode2_q <= mode2_d;
      acc2_q  <= acc2_d;
      b2_q    <= b2_d;
      data3_q <= data3_d;
`ifdef RGB2GRAY_THRESH_EN
      thr1_q  <= thr1_d;
      thr2_q  <= thr2_d;
      bin3_q  <= bin3_d;
`endif
    end
  end

  assign oDVAL = v3_q;
  assign oDATA = data3_q;
  assign oSOF  = sof3_q;
`ifdef RGB2GRAY_THRESH_EN
  assign oBIN  = bin3_q;
`endif

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Directed self-checking bench for rgb2gray_pipe: modes, corners, stalls, SOF, async reset.
module tb_rgb2gray_pipe;
  localparam int unsigned DW = 10;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iDVAL = 1'b0, iSOF = 1'b0, iMODE_OVR = 1'b1, iREADY = 1'b1;
  logic [1:0]    iMODE = 2'd0;
  logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic          oREADY, oDVAL, oSOF;
  logic [DW-1:0] oDATA;
`ifdef RGB2GRAY_THRESH_EN
  logic [DW-1:0] iTHRESH = '0;
  logic          oBIN;
`endif

  rgb2gray_pipe #(.DW(DW), .MODE_DEF(0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .oREADY(oREADY),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iSOF(iSOF),
    .iMODE_OVR(iMODE_OVR), .iMODE(iMODE), .oDVAL(oDVAL), .iREADY(iREADY),
    .oDATA(oDATA), .oSOF(oSOF)
`ifdef RGB2GRAY_THRESH_EN
    , .iTHRESH(iTHRESH), .oBIN(oBIN)
`endif
  );

  always #5 iCLK = ~iCLK;

  int checks = 0, failures = 0;
  int cyc = 0;
  int st_lo = -10, st_hi = -10, full_lo = -10, full_hi = -10;
  bit lat_chk = 1'b0, accepted = 1'b0, prev_stall = 1'b0, prev_sof = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int pend_e = 0, pend_s = 0, pend_b = 0;
  int exp_q[$], sof_q[$], bin_q[$], acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: observe at negedge, then return 1ns after the next rising edge.
  task automatic cycle();
    int e, s, b, a;
    @(negedge iCLK);
    cyc++;
    if (prev_stall) begin
      chk("hold_dval", oDVAL, 1);
      chk("hold_data", oDATA, prev_data);
      chk("hold_sof", oSOF, prev_sof);
    end
    if (cyc >= full_lo && cyc <= full_hi) chk("ready_full", oREADY, 0);
    if (oDVAL && iREADY) begin
      if (exp_q.size() == 0) chk("unexpected_out", oDVAL, 0);
      else begin
        e = exp_q.pop_front(); s = sof_q.pop_front();
        b = bin_q.pop_front(); a = acc_q.pop_front();
        chk("data", oDATA, e);
        chk("sof", oSOF, s);
`ifdef RGB2GRAY_THRESH_EN
        chk("bin", oBIN, b);
`endif
        if (lat_chk) chk("latency", cyc - a, 3);
      end
    end
    prev_stall = oDVAL && !iREADY;
    prev_data  = oDATA;
    prev_sof   = oSOF;
    accepted   = iDVAL && oREADY;
    if (accepted) begin
      exp_q.push_back(pend_e); sof_q.push_back(pend_s);
      bin_q.push_back(pend_b); acc_q.push_back(cyc);
    end
    @(posedge iCLK);
    #1;
    iREADY = !(cyc + 1 >= st_lo && cyc + 1 <= st_hi);
  endtask

  task automatic send(input int r, input int g, input int b, input int m,
                      input bit sof, input int e, input int eb);
    int n;
    iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b); iMODE = 2'(m);
    iSOF = sof; iDVAL = 1'b1;
    pend_e = e; pend_s = int'(sof); pend_b = eb;
    n = 0;
    do begin cycle(); n++; end while (!accepted && n < 50);
    chk("accept", accepted, 1);
    iDVAL = 1'b0; iSOF = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin cycle(); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_stall(input int lo, input int hi);
    st_lo = cyc + 1 + lo; st_hi = cyc + 1 + hi;
    iREADY = !(cyc + 1 >= st_lo && cyc + 1 <= st_hi);
  endtask

  initial begin
    int b0;
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_dval", oDVAL, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_sof", oSOF, 0);
    iRST = 1'b0;
    #1;
    chk("rst_ready", oREADY, 1);

    // Mode sweep, back-to-back, with latency checking.
    lat_chk = 1'b1;
    send(300, 600, 900, 0, 1'b0, 600, 0);
    send(300, 600, 900, 1, 1'b0, 544, 0);
    send(300, 600, 900, 2, 1'b0, 900, 0);
    send(300, 600, 900, 3, 1'b0, 600, 0);
    drain();
    lat_chk = 1'b0;

    // Corner values; then MODE_DEF (average) applies when override is low.
    send(1023, 1023, 1023, 0, 1'b0, 1023, 0);
    send(1023, 1023, 1023, 1, 1'b0, 1023, 0);
    send(1023, 1023, 1023, 2, 1'b0, 1023, 0);
    send(1023, 1023, 1023, 3, 1'b0, 1023, 0);
    send(1, 1, 0, 0, 1'b0, 0, 0);
    send(0, 0, 0, 1, 1'b0, 0, 0);
    send(10, 20, 700, 2, 1'b0, 700, 0);
    iMODE_OVR = 1'b0;
    send(300, 600, 900, 1, 1'b0, 600, 0);
    iMODE_OVR = 1'b1;
    drain();

    // SOF with a stall between accept and output.
    set_stall(0, 5);
    send(5, 700, 20, 2, 1'b1, 700, 0);
    send(30, 30, 30, 0, 1'b0, 30, 0);
    send(100, 100, 100, 1, 1'b0, 100, 0);
    drain();

    // 10-pixel burst, downstream stalled in burst cycles 4..9.
    b0 = cyc + 1;
    st_lo = b0 + 4; st_hi = b0 + 9;
    full_lo = b0 + 4; full_hi = b0 + 9;
    for (int i = 0; i < 10; i++) send(900 - i, 100 + i, 800, 3, i == 0, 100 + i, 0);
    drain();
    full_lo = -10; full_hi = -10;

    // Reset with three pixels in flight.
    set_stall(0, 1000);
    send(1, 2, 3, 3, 1'b0, 2, 0);
    send(4, 5, 6, 3, 1'b0, 5, 0);
    send(7, 8, 9, 3, 1'b0, 8, 0);
    chk("pre_rst_dval", oDVAL, 1);
    iRST = 1'b1;
    #1;
    chk("async_rst_dval", oDVAL, 0);
    chk("async_rst_data", oDATA, 0);
    #2;
    iRST = 1'b0;
    st_lo = -10; st_hi = -10; iREADY = 1'b1;
    exp_q.delete(); sof_q.delete(); bin_q.delete(); acc_q.delete();
    prev_stall = 1'b0;
    #1;
    chk("post_rst_ready", oREADY, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("post_rst_dval", oDVAL, 0);
    end
    send(50, 60, 70, 0, 1'b0, 60, 0);
    drain();

`ifdef RGB2GRAY_THRESH_EN
    iTHRESH = DW'(200);
    send(500, 199, 500, 3, 1'b0, 199, 1);
    send(0, 200, 0, 3, 1'b0, 200, 0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
- Parametrised, pipelined RGB-to-grayscale converter for the camera video path, ahead of the iris segmentation stages.
- Supports a configurable component width and four per-pixel conversion modes: average, BT.601 luma, max-channel and green-only.
- Uses a valid/ready handshake so downstream stalls propagate without losing or duplicating pixels.
- Carries a start-of-frame flag aligned with each pixel.

Parameters:
DW, 10, bit width of each colour component and of the gray output (range 8 to 12).
MODE_DEF, 0, mode applied when iMODE_OVR is low (0 avg, 1 BT.601, 2 max, 3 green).

Ports:
iCLK  input  1  pixel clock; all logic on the rising edge
iRST  input  1  asynchronous, active-high reset
iDVAL  input  1  input pixel valid
oREADY  output  1  block can accept a pixel this cycle
iRed  input  DW  red component
iGreen  input  DW  green component
iBlue  input  DW  blue component
iSOF  input  1  first pixel of frame flag, qualified by iDVAL
iMODE_OVR  input  1  1 = use iMODE, 0 = use MODE_DEF
iMODE  input  2  per-pixel mode select
oDVAL  output  1  output pixel valid
iREADY  input  1  downstream accepts the output this cycle
oDATA  output  DW  gray value
oSOF  output  1  iSOF delayed and aligned with oDATA

Behaviour:
- Reset: iRST is asynchronous and active-high.
  - Asserting it clears all stage valid bits immediately (no clock required).
  - Reset values: oDVAL=0, oDATA=0, oSOF=0, and oREADY=1 after reset is released.
  - Asserting reset mid-frame discards in-flight pixels. No partial output is produced afterwards.
- Handshakes:
  - Input transfer occurs when iDVAL & oREADY.
  - Output transfer occurs when oDVAL & iREADY.
- Pipeline: three register stages S1, S2, S3, each with its own valid bit.
  - A stage loads when it is empty, or when the stage after it is advancing in the same cycle (bubble collapsing).
  - oREADY = !S1.valid | S1 advancing. It is combinational from iREADY and the stage valid bits.
  - Latency is 3 cycles from input transfer to oDVAL when no stall occurs. Sustained throughput is 1 pixel per clock.
  - While oDVAL=1 and iREADY=0, oDATA and oSOF hold stable.
  - With all three stages full and iREADY=0, oREADY=0.
- S1 captures R, G, B, iSOF and the effective mode, so the mode travels with its pixel. Changing iMODE mid-stream affects only pixels accepted afterwards.
- S2 computes by mode:
  - 0: sum = R+G+B, in DW+2 bits.
  - 1: weighted sum = 77R+150G+29B+128, in DW+8 bits.
  - 2: max of R and G, carried with B.
  - 3: G.
- S3 produces the result:
  - 0: floor(sum/3), bit-exact for all inputs. Implemented as a constant multiply and shift, verified exhaustively for DW=8.
  - 1: weighted sum >>8. The weights total 256, so the result never exceeds 2^DW-1 and no saturation is needed.
  - 2: max(previous max, B).
  - 3: pass-through.
- oDATA is always exactly DW bits with no truncation overflow.
- Simultaneous input and output transfer on a full pipeline sustains full rate.

Optional Feature:
- Macro: RGB2GRAY_THRESH_EN.
- When defined:
  - Adds input iTHRESH [DW-1:0] and output oBIN [1].
  - oBIN = (gray < iTHRESH), computed in S3 and aligned with oDATA. This is a dark-pupil mask.
  - iTHRESH is sampled in S1 together with the pixel.
  - oBIN resets to 0 and holds during a stall.
- When undefined: iTHRESH and oBIN do not exist and no comparator is synthesised. All other behaviour is identical.

Test Plan:
- DW=10, iMODE_OVR=1, R=300 G=600 B=900, iREADY=1, one pixel per mode 0..3. Expected: oDATA = 600, 544, 900, 600, each 3 cycles after its own accept, in order.
- R=G=B=1023 in every mode -> oDATA=1023. R=1 G=1 B=0 in mode 0 -> oDATA=0. R=G=B=0 in mode 1 -> oDATA=0.
- 10-pixel burst with iREADY low in cycles 4-9:
  - oREADY drops once 3 pixels are held.
  - All 10 pixels emerge in order, with no loss or duplicate.
  - oDATA holds stable whenever oDVAL=1 and iREADY=0.
- iSOF=1 on pixel 0 only -> oSOF=1 only with pixel 0's output, including when a stall is applied between accept and output.
- Pulse iRST with 3 pixels in flight -> oDVAL=0 without a clock edge. After release: oREADY=1 and no stale pixel is ever output.
- RGB2GRAY_THRESH_EN defined, iTHRESH=200, mode 3, G=199 then G=200 -> oBIN = 1 then 0.
